// File: rtl/regfile_dump_reader_pkg.sv
// Shared CPU constants used by the register-file dump reader:
// register-file geometry and the 2-bit FSM state encoding.
package regfile_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through one register-file read port,
// streams each word over valid/ready and reports a wrapping 32-bit checksum.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum,
  output logic [REG_ADDR_W-1:0] rf_read_address,
  input  logic [DATA_W-1:0]     rf_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic [1:0]            state_q,    state_d;
  logic [REG_ADDR_W-1:0] cnt_q,      cnt_d;
  logic [DATA_W-1:0]     sum_q,      sum_d;
  logic [DATA_W-1:0]     data_q,     data_d;
  logic [REG_ADDR_W-1:0] index_q,    index_d;
  logic                  last_q,     last_d;
  logic                  done_q,     done_d;
  logic [DATA_W-1:0]     checksum_q, checksum_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    data_d     = data_q;
    index_d    = index_q;
    last_d     = last_q;
    done_d     = 1'b0;
    checksum_d = checksum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = FIRST_A;
          sum_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Snapshot of what the register file presents this cycle; a write
        // committing at this same edge is deliberately not seen.
        data_d  = rf_read_data;
        index_d = cnt_q;
        last_d  = (cnt_q == LAST_A);
        sum_d   = wrap_add(sum_q, rf_read_data);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: begin
        done_d     = 1'b1;
        checksum_d = sum_q;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= FIRST_A;
      sum_q      <= '0;
      data_q     <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      data_q     <= data_d;
      index_q    <= index_d;
      last_q     <= last_d;
      done_q     <= done_d;
      checksum_q <= checksum_d;
    end
  end

  // Address parks at FIRST_REG outside READ so the port is never undefined.
  assign rf_read_address = (state_q == ST_READ) ? cnt_q : FIRST_A;
  assign busy            = (state_q == ST_READ) || (state_q == ST_SEND);
  assign out_valid       = (state_q == ST_SEND);
  assign out_data        = data_q;
  assign out_index       = index_q;
  assign out_last        = last_q;
  assign done            = done_q;
  assign checksum        = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a full-range instance and a
// single-register (r7) instance share a behavioural 32x32 register file.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start7 = 1'b0;
  logic        out_ready = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rf [32];

  always @(posedge clk) if (we) rf[waddr] <= wdata;

  logic        busy0, done0, ov0, ol0;
  logic [31:0] cks0, od0, rd0;
  logic [4:0]  addr0, oi0;
  logic        busy7, done7, ov7, ol7;
  logic [31:0] cks7, od7, rd7;
  logic [4:0]  addr7, oi7;

  assign rd0 = rf[addr0];
  assign rd7 = rf[addr7];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .checksum(cks0), .rf_read_address(addr0), .rf_read_data(rd0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_index(oi0), .out_last(ol0));

  regfile_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
    .clk(clk), .reset(reset), .start(start7), .busy(busy7), .done(done7),
    .checksum(cks7), .rf_read_address(addr7), .rf_read_data(rd7),
    .out_valid(ov7), .out_ready(out_ready), .out_data(od7),
    .out_index(oi7), .out_last(ol7));

  bit          sel = 1'b0;
  logic        m_valid, m_done, m_busy;
  logic [31:0] m_data;
  logic [4:0]  m_index;
  logic        m_last;

  always_comb begin
    m_valid = sel ? ov7   : ov0;
    m_done  = sel ? done7 : done0;
    m_busy  = sel ? busy7 : busy0;
    m_data  = sel ? od7   : od0;
    m_index = sel ? oi7   : oi0;
    m_last  = sel ? ol7   : ol0;
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] cap_d [64];
  logic [4:0]  cap_i [64];
  logic        cap_l [64];
  int ncap, done_c, stab_err;

  // Sum of 0x01010101*i for i=0..31: each byte lane sums to 496 = 0x1F0,
  // carries ripple upward, giving 0xF1F1F1F0.
  localparam logic [31:0] FULL_SUM = 32'hF1F1F1F0;
  // FULL_SUM - 0x05050505 + 0x12345678 after r5 is rewritten.
  localparam logic [31:0] NEW_SUM  = 32'hFF214363;

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start7 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start7 = 1'b0;
  endtask

  // Records every handshake; c counts clock edges after the start edge.
  task automatic collect(input bit sel_i, input int mode, input bit spam, input int maxc);
    int c = 0;
    logic pend = 1'b0;
    logic [31:0] pd = '0;
    logic [4:0] pi = '0;
    sel = sel_i; ncap = 0; done_c = -1; stab_err = 0;
    while (c < maxc && done_c < 0) begin
      @(negedge clk);
      c++;
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (spam) begin
        if (sel_i) start7 = m_busy && (c % 3 == 0);
        else       start0 = m_busy && (c % 3 == 0);
      end
      if (pend && (!m_valid || m_data !== pd || m_index !== pi)) stab_err++;
      if (m_valid && out_ready && ncap < 64) begin
        cap_d[ncap] = m_data; cap_i[ncap] = m_index; cap_l[ncap] = m_last;
        ncap++;
      end
      pend = m_valid && !out_ready; pd = m_data; pi = m_index;
      if (m_done) done_c = c;
    end
    start0 = 1'b0; start7 = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_full_words(input string tag);
    for (int k = 0; k < 32; k++) begin
      logic [31:0] exp_d;
      exp_d = 32'h01010101 * 32'(k);
      if (k == 5 && tag == "snap_redump") exp_d = 32'h12345678;
      checks++;
      if (cap_i[k] !== 5'(k) || cap_d[k] !== exp_d || cap_l[k] !== (k == 31)) begin
        failures++;
        $display("FAIL %s word%0d: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                 tag, k, cap_i[k], cap_d[k], cap_l[k], k, exp_d, (k == 31));
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf_write(5'(i), 32'h01010101 * 32'(i));
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b need 0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done: got %b need 0", done0); end
    checks++; if (ov0 !== 1'b0 || ol0 !== 1'b0) begin failures++; $display("FAIL rst_valid_last: got %b%b need 00", ov0, ol0); end
    checks++; if (od0 !== 32'h0 || oi0 !== 5'd0 || cks0 !== 32'h0) begin failures++; $display("FAIL rst_data: data=%h idx=%0d cks=%h need 0", od0, oi0, cks0); end
    checks++; if (addr0 !== 5'd0 || addr7 !== 5'd7) begin failures++; $display("FAIL rst_addr: got %0d/%0d need 0/7", addr0, addr7); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || ov7 !== 1'b0) begin failures++; $display("FAIL idle_quiet: busy=%b ov7=%b need 0", busy0, ov7); end
  endtask

  task automatic test_full_dump();
    pulse_start(1'b0);
    collect(1'b0, 0, 1'b0, 200);
    checks++; if (done_c != 65) begin failures++; $display("FAIL full_done_cycle: got %0d need 65", done_c); end
    checks++; if (ncap != 32) begin failures++; $display("FAIL full_nwords: got %0d need 32", ncap); end
    check_full_words("full");
    checks++; if (cks0 !== FULL_SUM) begin failures++; $display("FAIL full_checksum: got %h need %h", cks0, FULL_SUM); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || cks0 !== FULL_SUM) begin failures++; $display("FAIL full_hold: done=%b cks=%h need 0/%h", done0, cks0, FULL_SUM); end
  endtask

  task automatic test_backpressure();
    pulse_start(1'b0);
    collect(1'b0, 1, 1'b0, 2000);
    checks++; if (ncap != 32) begin failures++; $display("FAIL bp_nwords: got %0d need 32", ncap); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes need 0", stab_err); end
    check_full_words("bp");
    checks++; if (cks0 !== FULL_SUM) begin failures++; $display("FAIL bp_checksum: got %h need %h", cks0, FULL_SUM); end
  endtask

  task automatic test_single_reg();
    rf_write(5'd7, 32'hDEADBEEF);
    pulse_start(1'b1);
    collect(1'b1, 0, 1'b0, 50);
    checks++; if (ncap != 1) begin failures++; $display("FAIL single_nwords: got %0d need 1", ncap); end
    checks++; if (cap_i[0] !== 5'd7 || cap_l[0] !== 1'b1 || cap_d[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_word: idx=%0d last=%b data=%h need 7/1/deadbeef", cap_i[0], cap_l[0], cap_d[0]); end
    checks++; if (done_c != 3) begin failures++; $display("FAIL single_done_cycle: got %0d need 3", done_c); end
    checks++; if (cks7 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_checksum: got %h need deadbeef", cks7); end
    rf_write(5'd7, 32'h07070707);
  endtask

  task automatic test_back_to_back_start();
    int extra_done = 0;
    int extra_busy = 0;
    pulse_start(1'b0);
    collect(1'b0, 0, 1'b1, 200);
    checks++; if (ncap != 32 || done_c != 65) begin failures++; $display("FAIL spam_dump: words=%0d done_at=%0d need 32/65", ncap, done_c); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done0) extra_done++;
      if (busy0) extra_busy++;
    end
    checks++; if (extra_done != 0 || extra_busy != 0) begin failures++; $display("FAIL spam_extra: done=%0d busy=%0d need 0/0", extra_done, extra_busy); end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    int seen_done = 0;
    pulse_start(1'b0);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ov0 && oi0 == 5'd10) begin
        out_ready = 1'b0; reset = 1'b1; found = 1'b1;
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_reach10: got 0 need 1"); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL mid_abort: valid=%b busy=%b need 0/0", ov0, busy0); end
    checks++; if (cks0 !== 32'h0) begin failures++; $display("FAIL mid_cks_cleared: got %h need 0", cks0); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done0) seen_done++;
    end
    checks++; if (seen_done != 0) begin failures++; $display("FAIL mid_no_done: got %0d need 0", seen_done); end
    out_ready = 1'b1;
    pulse_start(1'b0);
    collect(1'b0, 0, 1'b0, 200);
    checks++; if (ncap != 32 || cap_i[0] !== 5'd0 || cks0 !== FULL_SUM) begin
      failures++; $display("FAIL mid_restart: words=%0d first=%0d cks=%h need 32/0/%h", ncap, cap_i[0], cks0, FULL_SUM); end
  endtask

  task automatic test_snapshot();
    bit wrote = 1'b0;
    bit fin = 1'b0;
    logic [31:0] got5 = '0;
    out_ready = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      we = 1'b0;
      if (!wrote && busy0 && !ov0 && addr0 == 5'd5) begin
        we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; wrote = 1'b1;
      end
      if (ov0 && oi0 == 5'd5) got5 = od0;
      if (done0) fin = 1'b1;
    end
    we = 1'b0;
    checks++; if (!wrote || got5 !== 32'h05050505) begin failures++; $display("FAIL snap_old: got %h need 05050505", got5); end
    checks++; if (cks0 !== FULL_SUM) begin failures++; $display("FAIL snap_checksum: got %h need %h", cks0, FULL_SUM); end
    pulse_start(1'b0);
    collect(1'b0, 0, 1'b0, 200);
    check_full_words("snap_redump");
    checks++; if (cks0 !== NEW_SUM) begin failures++; $display("FAIL snap_new_checksum: got %h need %h", cks0, NEW_SUM); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single_reg();
    test_back_to_back_start();
    test_reset_mid_dump();
    test_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
